// File: rtl/hex_display_scanner.sv
// Time-multiplexed N-digit common-anode seven-segment driver with guard blanking and per-frame input snapshot.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zero digits; digit 0 is always shown).
module hex_display_scanner #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] data,
   input  logic [NUM_DIGITS-1:0]   digitEnable,
   input  logic [NUM_DIGITS-1:0]   dp,
   output logic [6:0]              sevenSeg,
   output logic                    dpOut,
   output logic [NUM_DIGITS-1:0]   anode
);

   // state   | meaning
   // S_GUARD | cnt < BLANK_CYCLES: everything dark so the previous digit cannot ghost
   // S_SHOW  | selected digit driven from the frame snapshot
   typedef enum logic {S_GUARD, S_SHOW} slot_t;

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [CNT_W-1:0]        cnt;
   logic [IDX_W-1:0]        idx;
   logic [4*NUM_DIGITS-1:0] snap_data;
   logic [NUM_DIGITS-1:0]   snap_en;
   logic [NUM_DIGITS-1:0]   snap_dp;
   logic                    cnt_wrap;
   logic                    frame_wrap;
   slot_t                   slot;
   logic [NUM_DIGITS-1:0]   lz_blank;
   logic [3:0]              nibble;
   logic [6:0]              seg_nxt;
   logic                    dp_nxt;
   logic [NUM_DIGITS-1:0]   an_nxt;

   function automatic logic [6:0] decode(input logic [3:0] h);
      case (h)
         4'h0: decode = 7'b1000000;
         4'h1: decode = 7'b1111001;
         4'h2: decode = 7'b0100100;
         4'h3: decode = 7'b0110000;
         4'h4: decode = 7'b0011001;
         4'h5: decode = 7'b0010010;
         4'h6: decode = 7'b0000010;
         4'h7: decode = 7'b1111000;
         4'h8: decode = 7'b0000000;
         4'h9: decode = 7'b0010000;
         4'hA: decode = 7'b0001000;
         4'hB: decode = 7'b0000011;
         4'hC: decode = 7'b1000110;
         4'hD: decode = 7'b0100001;
         4'hE: decode = 7'b0000110;
         default: decode = 7'b0001110;
      endcase
   endfunction

   assign cnt_wrap   = (cnt == CNT_W'(REFRESH_DIV - 1));
   assign frame_wrap = cnt_wrap && (idx == IDX_W'(NUM_DIGITS - 1));

   always_comb begin
      slot = S_SHOW;
      if (cnt < CNT_W'(BLANK_CYCLES)) slot = S_GUARD;
   end

`ifdef LEADING_ZERO_BLANK_EN
   // Walk down from the most significant nibble; a digit is blanked while all nibbles above and at it are zero.
   always_comb begin
      logic all_zero;
      all_zero = 1'b1;
      lz_blank = '0;
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
         all_zero    = all_zero && (snap_data[4*k +: 4] == 4'h0);
         lz_blank[k] = all_zero;
      end
   end
`else
   assign lz_blank = '0;
`endif

   always_comb begin
      seg_nxt = 7'h7F;
      dp_nxt  = 1'b1;
      an_nxt  = '1;
      nibble  = snap_data[4*idx +: 4];
      if (slot == S_SHOW && snap_en[idx] && !lz_blank[idx]) begin
         seg_nxt = decode(nibble);
         dp_nxt  = ~snap_dp[idx];
         an_nxt  = ~(NUM_DIGITS'(1) << idx);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         idx       <= '0;
         snap_data <= data;
         snap_en   <= digitEnable;
         snap_dp   <= dp;
         sevenSeg  <= 7'h7F;
         dpOut     <= 1'b1;
         anode     <= '1;
      end else begin
         sevenSeg <= seg_nxt;
         dpOut    <= dp_nxt;
         anode    <= an_nxt;
         if (cnt_wrap) begin
            cnt <= '0;
            idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
         // Inputs are only sampled at frame boundaries so a frame never mixes old and new values.
         if (frame_wrap) begin
            snap_data <= data;
            snap_en   <= digitEnable;
            snap_dp   <= dp;
         end
      end
   end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner: a positional reference model queues expected outputs, a monitor compares.
module tb_hex_display_scanner;

   localparam int ND    = 4;
   localparam int DIV   = 8;
   localparam int BLANK = 2;
   localparam int FRAME = ND * DIV;

   typedef struct packed {
      logic [6:0] seg;
      logic       dpo;
      logic [3:0] an;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [15:0] data;
   logic [3:0]  digitEnable;
   logic [3:0]  dp;
   logic [6:0]  sevenSeg;
   logic        dpOut;
   logic [3:0]  anode;

   exp_t        exp_q[$];
   int          checks;
   int          fails;

   logic [6:0]  seg_tab[16];
   int          p;
   logic [15:0] m_data;
   logic [3:0]  m_en;
   logic [3:0]  m_dp;

   hex_display_scanner #(
      .NUM_DIGITS  (ND),
      .REFRESH_DIV (DIV),
      .BLANK_CYCLES(BLANK)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .data       (data),
      .digitEnable(digitEnable),
      .dp         (dp),
      .sevenSeg   (sevenSeg),
      .dpOut      (dpOut),
      .anode      (anode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic lead_zero(input int dig);
`ifdef LEADING_ZERO_BLANK_EN
      return (dig > 0) && ((m_data >> (4 * dig)) == 16'h0);
`else
      return 1'b0;
`endif
   endfunction

   // Output after the k-th edge since reset is fully determined by k and the frame's snapshot.
   task automatic model_edge();
      exp_t       e;
      int         pos;
      int         dig;
      int         ph;
      logic [3:0] nib;
      e = '{seg: 7'h7F, dpo: 1'b1, an: 4'hF};
      if (reset) begin
         m_data = data;
         m_en   = digitEnable;
         m_dp   = dp;
         p      = 0;
      end else begin
         pos = p % FRAME;
         dig = pos / DIV;
         ph  = pos % DIV;
         nib = 4'((m_data >> (4 * dig)) & 16'hF);
         if (ph >= BLANK && m_en[dig] && !lead_zero(dig)) begin
            e.seg = seg_tab[nib];
            e.dpo = ~m_dp[dig];
            e.an  = ~(4'b0001 << dig);
         end
         if (pos == FRAME - 1) begin
            m_data = data;
            m_en   = digitEnable;
            m_dp   = dp;
         end
         p++;
      end
      exp_q.push_back(e);
   endtask

   task automatic step(input logic rst, input logic [15:0] d, input logic [3:0] en, input logic [3:0] dpi);
      @(negedge clk);
      reset       = rst;
      data        = d;
      digitEnable = en;
      dp          = dpi;
      model_edge();
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({sevenSeg, dpOut, anode} !== {e.seg, e.dpo, e.an}) begin
               fails++;
               $display("FAIL scan_out t=%0t: got seg=%b dp=%b an=%b, want seg=%b dp=%b an=%b",
                        $time, sevenSeg, dpOut, anode, e.seg, e.dpo, e.an);
            end
            checks++;
            if ($countones(~anode) > 1) begin
               fails++;
               $display("FAIL anode_onehot t=%0t: got an=%b, want at most one low bit", $time, anode);
            end
         end
      end
   end

   initial begin
      logic [15:0] words[5];
      logic [15:0] d;
      seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      checks      = 0;
      fails       = 0;
      p           = 0;
      reset       = 1'b1;
      data        = 16'h1234;
      digitEnable = 4'hF;
      dp          = 4'h0;

      // reset sequencing
      repeat (3) step(1'b1, 16'h1234, 4'hF, 4'h0);
      repeat (40) step(1'b0, 16'h1234, 4'hF, 4'h0);

      // decode sweep, one word per frame
      words = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC, 16'hFEDC};
      step(1'b1, words[0], 4'hF, 4'h0);
      for (int i = 0; i < 4; i++)
         for (int c = 0; c < FRAME; c++)
            step(1'b0, (c == FRAME - 1) ? words[i + 1] : words[i], 4'hF, 4'h0);

      // mid-frame change must wait for the next frame
      step(1'b1, 16'hAAAA, 4'hF, 4'h0);
      repeat (2 * DIV) step(1'b0, 16'hAAAA, 4'hF, 4'h0);
      repeat (3 * DIV) step(1'b0, 16'h5555, 4'hF, 4'h0);

      // enable and decimal point
      step(1'b1, 16'h9876, 4'b0101, 4'b0001);
      repeat (2 * FRAME) step(1'b0, 16'h9876, 4'b0101, 4'b0001);

      // reset during digit 2 SHOW
      step(1'b1, 16'h1234, 4'hF, 4'hF);
      repeat (2 * DIV + 4) step(1'b0, 16'h1234, 4'hF, 4'hF);
      step(1'b1, 16'h1234, 4'hF, 4'hF);
      repeat (FRAME + 8) step(1'b0, 16'h1234, 4'hF, 4'hF);

      // leading zeros
      step(1'b1, 16'h0050, 4'hF, 4'h2);
      repeat (2 * FRAME) step(1'b0, 16'h0050, 4'hF, 4'h2);

      // randomized traffic, including sparse resets and small values
      repeat (800) begin
         d = 16'($urandom);
         if ($urandom_range(0, 2) == 0) d = d >> (4 * $urandom_range(1, 3));
         step($urandom_range(0, 199) == 0, d,
              ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF, 4'($urandom));
      end

      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/hex_display_scanner.md
# hex_display_scanner

Time-multiplexed driver for an N-digit common-anode seven-segment display, the parametrised successor to the single-digit hex-to-seven-segment decoder. Accepts a packed hex word, and scans one digit at a time at a programmable refresh rate. Inserts guard (blank) cycles between digits to suppress ghosting and latches a frame-consistent snapshot of its inputs. Sits between datapath/status registers and the board display pins.

## Interface
- NUM_DIGITS, 4: digits driven; ≥1.
- REFRESH_DIV, 50000: clocks per digit slot; ≥2.
- BLANK_CYCLES, 500: guard clocks at the start of each slot; 0 ≤ BLANK_CYCLES < REFRESH_DIV.
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- data  in  4*NUM_DIGITS  hex nibbles; data[4k+3:4k] is digit k (k=0 least significant).
- digitEnable  in  NUM_DIGITS  1 = digit k shown, 0 = digit k forced blank.
- dp  in  NUM_DIGITS  1 = decimal point lit on digit k.
- sevenSeg  out  7  segment cathodes, active low; seg[0]=a (top), [1]=b (upper right), [2]=c (lower right), [3]=d (bottom), [4]=e (lower left), [5]=f (upper left), [6]=g (middle).
- dpOut  out  1  decimal-point cathode, active low.
- anode  out  NUM_DIGITS  digit select, active low, at most one bit low at any time.

## Operation
- Prescaler cnt counts 0..REFRESH_DIV-1, then wraps to 0. On the wrap, digit index idx increments mod NUM_DIGITS.
- Snapshot registers hold data, digitEnable, and dp. They load on every reset cycle and on the clock where idx wraps NUM_DIGITS-1→0 with cnt wrapping. Input changes mid-frame never appear until the next frame.
- Slot states are GUARD when cnt < BLANK_CYCLES, otherwise SHOW.
  - GUARD: anode all 1, sevenSeg=7'h7F, dpOut=1.
  - SHOW with snapshot digitEnable[idx]=1: anode[idx]=0, sevenSeg=decode(nibble idx), dpOut=~dp[idx].
  - SHOW with digitEnable[idx]=0: outputs as in GUARD.
- Decode, sevenSeg[6:0]:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- NUM_DIGITS=1: idx is constant 0. The snapshot reloads every REFRESH_DIV clocks.
- Counter widths are $clog2 of the respective range, with minimum 1 bit.

## Timing
- Reset values: sevenSeg=7'h7F, dpOut=1, anode all 1, cnt=0, idx=0.
- All outputs are registered. They reflect (cnt, idx, snapshot) of the previous clock, so output latency is 1 clock.
- First clock after reset deassertion: cnt=0 and idx=0. Outputs show GUARD for BLANK_CYCLES clocks, then digit 0 for REFRESH_DIV-BLANK_CYCLES clocks.
- Full frame = NUM_DIGITS*REFRESH_DIV clocks. Each anode is low for exactly REFRESH_DIV-BLANK_CYCLES consecutive clocks per frame.
- BLANK_CYCLES=0: no guard. Anodes switch directly between adjacent digits on a single edge, never two low simultaneously.
- Reset asserted mid-slot: on the next edge all outputs return to reset values, regardless of state.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - In SHOW, digit k>0 is additionally blanked when snapshot nibbles k..NUM_DIGITS-1 are all 0.
  - Digit 0 is never blanked by this rule.
  - Blanking by this rule drives anode high and forces dpOut=1.
- LEADING_ZERO_BLANK_EN undefined: every enabled digit is shown, including leading zeros.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset sequencing: hold reset 3 clocks with data=16'h1234 -> outputs 7F/1/4'hF during reset. After release: 2 guard clocks, then anode=4'b1110 with sevenSeg=0011001 for 6 clocks, then anode=4'b1101 with sevenSeg=0110000.
- Full decode sweep: data=16'h3210, then 16'h7654, 16'hBA98, 16'hFEDC, each held one frame -> every nibble 0–F produces its table pattern on the correct anode.
- Frame consistency: change data from 16'hAAAA to 16'h5555 while idx=2 -> digits 2 and 3 still show A. The first 5 appears on digit 0 of the next frame.
- Enable and decimal point: digitEnable=4'b0101, dp=4'b0001 -> digits 1 and 3 are never selected; dpOut=0 only during digit 0 SHOW; anode is never multi-low.
- Reset mid-operation: assert reset during digit 2 SHOW -> outputs are at reset values on the next edge; the scan restarts at digit 0 with a guard period after release.
- Leading-zero blanking: data=16'h0050 with LEADING_ZERO_BLANK_EN -> digits 0 and 1 are shown, digits 2 and 3 stay dark. Without the macro -> all four digits are shown.
